// File: rtl/wb_valid_arbiter.sv
// rtl/wb_valid_arbiter.sv - round-robin arbiter of writeback sources onto three RAT valid-update ports
module wb_valid_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int PHYS_W  = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       swap,
    input  logic [NUM_SRC-1:0]         src_valid,
    output logic [NUM_SRC-1:0]         src_ready,
    input  logic [NUM_SRC*5-1:0]       src_arch_rd,
    input  logic [NUM_SRC*PHYS_W-1:0]  src_phys_rd,
    output logic [2:0]                 port_valid,
    output logic [14:0]                port_arch,
    output logic [3*PHYS_W-1:0]        port_phys,
    output logic [15:0]                conflict_cnt
);
    localparam int PTR_W = $clog2(NUM_SRC);

    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    rr_next;
    logic [NUM_SRC-1:0]  live;
    logic [NUM_SRC-1:0]  zero_dst;
    logic [NUM_SRC-1:0]  grant;
    logic                any_denied;
    logic [2:0]          nxt_valid;
    logic [14:0]         nxt_arch;
    logic [3*PHYS_W-1:0] nxt_phys;
    logic                discard;

    assign discard = flush | swap;

    always_comb begin
        live     = '0;
        zero_dst = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            live[i]     = src_valid[i] && (src_arch_rd[5*i +: 5] != 5'd0);
            zero_dst[i] = src_valid[i] && (src_arch_rd[5*i +: 5] == 5'd0);
        end
    end

    // Circular scan from rr_ptr; the j-th live requester found lands on port j.
    always_comb begin
        int n;
        int idx;
        n          = 0;
        idx        = 0;
        grant      = '0;
        any_denied = 1'b0;
        nxt_valid  = '0;
        nxt_arch   = '0;
        nxt_phys   = '0;
        rr_next    = rr_ptr;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_SRC;
            if (live[idx]) begin
                if (n < 3) begin
                    grant[idx]                 = 1'b1;
                    nxt_valid[n]               = 1'b1;
                    nxt_arch[5*n +: 5]         = src_arch_rd[5*idx +: 5];
                    nxt_phys[PHYS_W*n +: PHYS_W] = src_phys_rd[PHYS_W*idx +: PHYS_W];
                    rr_next                    = PTR_W'((idx + 1) % NUM_SRC);
                    n                          = n + 1;
                end else begin
                    any_denied = 1'b1;
                end
            end
        end
        if (!any_denied) begin
            rr_next = rr_ptr;
        end
    end

    always_comb begin
        if (rst) begin
            src_ready = '0;
        end else if (discard) begin
            src_ready = '1;
        end else begin
            src_ready = grant | zero_dst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            port_valid   <= '0;
            port_arch    <= '0;
            port_phys    <= '0;
            rr_ptr       <= '0;
            conflict_cnt <= '0;
        end else if (discard) begin
            port_valid <= '0;
            port_arch  <= '0;
            port_phys  <= '0;
            rr_ptr     <= '0;
        end else begin
            port_valid <= nxt_valid;
            port_arch  <= nxt_arch;
            port_phys  <= nxt_phys;
            rr_ptr     <= rr_next;
            if (any_denied && conflict_cnt != 16'hFFFF) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_wb_valid_arbiter.sv
// tb/tb_wb_valid_arbiter.sv - directed vector bench for wb_valid_arbiter
module tb_wb_valid_arbiter;
    logic        clk;
    logic        rst;
    logic        flush;
    logic        swap;
    logic [3:0]  src_valid;
    logic [3:0]  src_ready;
    logic [19:0] src_arch_rd;
    logic [23:0] src_phys_rd;
    logic [2:0]  port_valid;
    logic [14:0] port_arch;
    logic [17:0] port_phys;
    logic [15:0] conflict_cnt;

    int tests;
    int fails;

    wb_valid_arbiter #(.NUM_SRC(4), .PHYS_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush), .swap(swap),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_arch_rd(src_arch_rd), .src_phys_rd(src_phys_rd),
        .port_valid(port_valid), .port_arch(port_arch), .port_phys(port_phys),
        .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        fl;
        logic        sw;
        logic [3:0]  v;
        logic [19:0] a;
        logic [23:0] p;
        logic [3:0]  rdy;
        logic [2:0]  pv;
        logic [14:0] pa;
        logic [17:0] pp;
        logic [15:0] cnt;
    } vec_t;

    localparam logic [19:0] A4 = {5'd4, 5'd3, 5'd2, 5'd1};
    localparam logic [23:0] P4 = {6'd13, 6'd12, 6'd11, 6'd10};

    vec_t tbl [18];
    int   gcount [4];

    function automatic vec_t mk(logic fl, logic sw, logic [3:0] v, logic [19:0] a, logic [23:0] p,
                                logic [3:0] rdy, logic [2:0] pv, logic [14:0] pa, logic [17:0] pp,
                                logic [15:0] cnt);
        vec_t r;
        r.fl = fl; r.sw = sw; r.v = v; r.a = a; r.p = p;
        r.rdy = rdy; r.pv = pv; r.pa = pa; r.pp = pp; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic sw, input logic [3:0] v,
                         input logic [19:0] a, input logic [23:0] p);
        flush = fl; swap = sw; src_valid = v; src_arch_rd = a; src_phys_rd = p;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 4; i++) gcount[i] = 0;

        // Expected port fields are packed {port2, port1, port0}.
        tbl[0]  = mk(0, 0, 4'b0100, {5'd0, 5'd5, 5'd0, 5'd0}, {6'd0, 6'd40, 6'd0, 6'd0},
                     4'b0100, 3'b001, {5'd0, 5'd0, 5'd5}, {6'd0, 6'd0, 6'd40}, 16'd0);
        tbl[1]  = mk(0, 0, 4'b1111, A4, P4, 4'b0111, 3'b111,
                     {5'd3, 5'd2, 5'd1}, {6'd12, 6'd11, 6'd10}, 16'd1);
        tbl[2]  = mk(0, 0, 4'b1000, A4, P4, 4'b1000, 3'b001,
                     {5'd0, 5'd0, 5'd4}, {6'd0, 6'd0, 6'd13}, 16'd1);
        tbl[3]  = mk(0, 0, 4'b0011, {5'd0, 5'd0, 5'd7, 5'd0}, {6'd0, 6'd0, 6'd20, 6'd5},
                     4'b0011, 3'b001, {5'd0, 5'd0, 5'd7}, {6'd0, 6'd0, 6'd20}, 16'd1);
        tbl[4]  = mk(1, 0, 4'b1111, A4, P4, 4'b1111, 3'b000, 15'd0, 18'd0, 16'd1);
        for (int r = 0; r < 2; r++) begin
            tbl[5+4*r] = mk(0, 0, 4'b1111, A4, P4, 4'b0111, 3'b111,
                            {5'd3, 5'd2, 5'd1}, {6'd12, 6'd11, 6'd10}, 16'(2 + 4*r));
            tbl[6+4*r] = mk(0, 0, 4'b1111, A4, P4, 4'b1011, 3'b111,
                            {5'd2, 5'd1, 5'd4}, {6'd11, 6'd10, 6'd13}, 16'(3 + 4*r));
            tbl[7+4*r] = mk(0, 0, 4'b1111, A4, P4, 4'b1101, 3'b111,
                            {5'd1, 5'd4, 5'd3}, {6'd10, 6'd13, 6'd12}, 16'(4 + 4*r));
            tbl[8+4*r] = mk(0, 0, 4'b1111, A4, P4, 4'b1110, 3'b111,
                            {5'd4, 5'd3, 5'd2}, {6'd13, 6'd12, 6'd11}, 16'(5 + 4*r));
        end
        tbl[13] = mk(0, 0, 4'b1111, A4, P4, 4'b0111, 3'b111,
                     {5'd3, 5'd2, 5'd1}, {6'd12, 6'd11, 6'd10}, 16'd10);
        tbl[14] = mk(0, 1, 4'b1111, A4, P4, 4'b1111, 3'b000, 15'd0, 18'd0, 16'd10);
        tbl[15] = mk(0, 0, 4'b1111, A4, P4, 4'b0111, 3'b111,
                     {5'd3, 5'd2, 5'd1}, {6'd12, 6'd11, 6'd10}, 16'd11);
        tbl[16] = mk(1, 1, 4'b1111, A4, P4, 4'b1111, 3'b000, 15'd0, 18'd0, 16'd11);
        tbl[17] = mk(0, 0, 4'b1111, A4, P4, 4'b0111, 3'b111,
                     {5'd3, 5'd2, 5'd1}, {6'd12, 6'd11, 6'd10}, 16'd12);

        // Reset with traffic present: ready must stay low, outputs clear.
        rst = 1'b1;
        drive(0, 0, 4'b1111, A4, P4);
        #1;
        @(posedge clk);
        #1;
        chk("reset_ready", 32'(src_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("reset_pvalid", 32'(port_valid), 32'h0);
        chk("reset_parch", 32'(port_arch), 32'h0);
        chk("reset_pphys", 32'(port_phys), 32'h0);
        chk("reset_cnt", 32'(conflict_cnt), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].fl, tbl[i].sw, tbl[i].v, tbl[i].a, tbl[i].p);
            #1;
            chk($sformatf("v%0d_ready", i), 32'(src_ready), 32'(tbl[i].rdy));
            if (i >= 5 && i <= 12) begin
                for (int s = 0; s < 4; s++) gcount[s] += int'(src_ready[s]);
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pvalid", i), 32'(port_valid), 32'(tbl[i].pv));
            chk($sformatf("v%0d_parch", i), 32'(port_arch), 32'(tbl[i].pa));
            chk($sformatf("v%0d_pphys", i), 32'(port_phys), 32'(tbl[i].pp));
            chk($sformatf("v%0d_cnt", i), 32'(conflict_cnt), 32'(tbl[i].cnt));
        end
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("fair_grants_src%0d", s), 32'(gcount[s]), 32'd6);
        end

        // Saturation: keep four live requesters contending.
        drive(0, 0, 4'b1111, A4, P4);
        repeat (70000) @(posedge clk);
        #1;
        chk("sat_cnt", 32'(conflict_cnt), 32'hFFFF);
        @(posedge clk);
        #1;
        chk("sat_hold", 32'(conflict_cnt), 32'hFFFF);
        chk("sat_pvalid", 32'(port_valid), 32'h7);

        // Reset mid-operation drops the pending grant.
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(src_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("midrst_pvalid", 32'(port_valid), 32'h0);
        chk("midrst_parch", 32'(port_arch), 32'h0);
        chk("midrst_pphys", 32'(port_phys), 32'h0);
        chk("midrst_cnt", 32'(conflict_cnt), 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(src_ready), 32'h7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wb_valid_arbiter.md
# wb_valid_arbiter

Shares the register alias table's three physical-register valid-update ports among `NUM_SRC` writeback sources, such as the ALU, multiplier, load/store and branch units. Each source presents at most one completed destination per cycle over a valid/ready handshake. Up to three accepted writebacks are forwarded per cycle through registered outputs, with round-robin fairness. Flush and thread-swap events discard all traffic.

## Interface
- NUM_SRC, 4: number of writeback requesters, range 2..8.
- PHYS_W, 6: physical register index width, equal to $clog2(NUM_REGS).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  pipeline flush; discard all traffic.
- swap  in  1  hardware-scheduler thread swap; same effect as flush.
- src_valid  in  NUM_SRC  source i holds a completed writeback.
- src_ready  out  NUM_SRC  source i's writeback is consumed this cycle.
- src_arch_rd  in  NUM_SRC*5  architectural destination, source i at bits [5i+4:5i].
- src_phys_rd  in  NUM_SRC*PHYS_W  physical destination, source i at bits [PHYS_W*i+PHYS_W-1:PHYS_W*i].
- port_valid  out  3  port k carries a valid update; drives update_valid, update_valid_mul and update_valid_ldst.
- port_arch  out  3*5  architectural register for port k.
- port_phys  out  3*PHYS_W  physical register for port k.
- conflict_cnt  out  16  saturating count of cycles in which a request was denied.

## Operation
- Request classes, evaluated each cycle:
  - Zero-destination: src_valid=1 and arch_rd==0. Always consumed (ready=1). Never occupies a port.
  - Live: src_valid=1 and arch_rd!=0.
- Grant: scan live requesters in circular order starting at rr_ptr. The first three found are granted, ready=1.
  - The j-th granted source, j=0..2, is assigned to port j.
  - Remaining live requesters get ready=0 and must hold valid and data stable until granted.
- rr_ptr, log2 of NUM_SRC bits, reset 0:
  - If at least one live requester was denied, rr_ptr moves to (index of last granted source + 1) mod NUM_SRC.
  - Otherwise rr_ptr is unchanged.
- Starvation bound: a held live request is granted within ceil(NUM_SRC/3) cycles after its first denial.
- Flush or swap asserted, including both at once:
  - All src_ready=1, so every presented request is sunk and discarded.
  - No grants are made. The next-cycle port_valid is 0.
  - rr_ptr is set to 0. conflict_cnt is unaffected.
- conflict_cnt: increments by 1 in any non-flush cycle with at least one denied live requester. It saturates at 0xFFFF.
- Duplicate physical destinations across sources in one cycle are not checked. Upstream guarantees they do not occur.

## Timing
- src_ready is combinational from src_valid, src_arch_rd, rr_ptr, flush and swap. There is no combinational path from port outputs.
- Grant-to-output latency is 1 cycle. In the cycle after a grant, port_valid[k]=1 and port_arch/port_phys hold the granted source's data. All port outputs are registered.
- An unused port has port_valid=0. Its port_arch and port_phys are 0.
- Reset values: port_valid=0, port_arch=0, port_phys=0, rr_ptr=0, conflict_cnt=0. src_ready is 0 in the reset cycle.
- Reset asserted mid-operation drops any pending grant. Outputs read reset values on the next edge.
- A flush in cycle N clears the port outputs registered at the end of N. Outputs registered at the end of N-1 are still visible during N. The RAT is responsible for ignoring them.

## Test plan
- Single source: src2 presents arch=5, phys=40.
  - ready[2]=1 in the same cycle.
  - Next cycle: port_valid=001, port_arch[0]=5, port_phys[0]=40.
  - conflict_cnt stays 0.
- Four live sources, rr_ptr=0: arch 1/2/3/4, phys 10/11/12/13.
  - Cycle 0: ready=0111, rr_ptr becomes 3. Next-cycle ports show (1,10), (2,11), (3,12).
  - Cycle 1: src3 is still held and is granted. Port 0 shows (4,13).
  - conflict_cnt=1.
- Zero destination: src0 arch=0 plus src1 arch=7.
  - ready=0011.
  - Next cycle: only port 0 is valid, showing arch=7.
- Fairness: all four sources continuously valid for 8 cycles.
  - Grant pattern rotates: 0111, 1011, 1101, 1110.
  - Each source is granted 6 times over the 8 cycles.
- Flush: all four valid, flush=1 in cycle N.
  - ready=1111 in cycle N.
  - port_valid=000 in cycle N+1, and rr_ptr=0.
  - Repeat the same stimulus with swap=1 instead of flush; the response is identical.
- Saturation and reset:
  - Force conflicts for 70000 cycles; conflict_cnt holds at 0xFFFF.
  - Assert rst; all outputs and conflict_cnt read 0 on the next cycle.
